// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam int CMD_W  = 8;
  localparam int RW_BIT = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with registered rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic rise_r;
  logic fall_r;

  // Synchronise the pin and register one-cycle edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      prev_r <= RST_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
      rise_r <= sync_r & ~prev_r;
      fall_r <= ~sync_r & prev_r;
    end
  end

  assign level = sync_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave giving command-addressed access to a flat register bank.
// Define SPI_REG_AUTOINC_EN to step the address after every data word.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  localparam int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         SCLK,
  input  logic                         MOSI,
  input  logic                         CE0,
  output logic                         MISO,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         xact_done
);

  localparam int SH_W  = (DATA_W > CMD_W) ? DATA_W : CMD_W;
  localparam int CNT_W = 6;

  logic sclk_level_unused_s;
  logic sclk_rise_s;
  logic sclk_fall_s;
  logic ce_level_s;
  logic ce_rise_s;
  logic ce_fall_s;
  logic mosi_meta_r;
  logic mosi_sync_r;

  state_t                           state_r;
  logic [CNT_W-1:0]                 bit_cnt_r;
  logic [SH_W-1:0]                  rx_shift_r;
  logic [DATA_W-1:0]                tx_shift_r;
  logic                             rw_r;
  logic [ADDR_W-1:0]                addr_r;
  logic                             cmd_seen_r;
  logic                             armed_r;
  logic [1:0]                       settle_r;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_r;
  logic                             miso_r;
  logic                             wr_strobe_r;
  logic [ADDR_W-1:0]                wr_addr_r;
  logic                             xact_done_r;

  logic [CMD_W-1:0]  cmd_s;
  logic [DATA_W-1:0] word_s;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic              unused_bits_s;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (SCLK),
    .level (sclk_level_unused_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_ce_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (CE0),
    .level (ce_level_s),
    .rise  (ce_rise_s),
    .fall  (ce_fall_s)
  );

  // MOSI needs only a level synchroniser; it is sampled on SCLK rise pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      mosi_meta_r <= MOSI;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  assign cmd_s         = {rx_shift_r[CMD_W-2:0], mosi_sync_r};
  assign word_s        = {rx_shift_r[DATA_W-2:0], mosi_sync_r};
  assign cmd_addr_s    = cmd_s[ADDR_W-1:0];
  assign unused_bits_s = ^{cmd_s, rx_shift_r};

`ifdef SPI_REG_AUTOINC_EN
  assign next_addr_s = addr_r + ADDR_W'(1'b1);
`else
  assign next_addr_s = addr_r;
`endif

  // Frame FSM, register bank and all registered outputs.
  // armed_r blocks frame starts until CE0 has been seen high after reset,
  // once the synchroniser reset values have flushed out (settle_r).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      bit_cnt_r   <= '0;
      rx_shift_r  <= '0;
      tx_shift_r  <= '0;
      rw_r        <= 1'b0;
      addr_r      <= '0;
      cmd_seen_r  <= 1'b0;
      armed_r     <= 1'b0;
      settle_r    <= 2'd0;
      regs_r      <= '0;
      miso_r      <= 1'b0;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= '0;
      xact_done_r <= 1'b0;
    end else begin
      wr_strobe_r <= 1'b0;
      xact_done_r <= 1'b0;
      if (settle_r != 2'd3) settle_r <= settle_r + 2'd1;
      if ((settle_r == 2'd3) && ce_level_s) armed_r <= 1'b1;

      if (ce_rise_s) begin
        state_r     <= IDLE;
        bit_cnt_r   <= '0;
        miso_r      <= 1'b0;
        xact_done_r <= cmd_seen_r;
        cmd_seen_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            miso_r    <= 1'b0;
            bit_cnt_r <= '0;
            if (ce_fall_s && armed_r) begin
              state_r    <= CMD;
              cmd_seen_r <= 1'b0;
            end
          end
          CMD: begin
            if (sclk_rise_s) begin
              rx_shift_r <= {rx_shift_r[SH_W-2:0], mosi_sync_r};
              if (bit_cnt_r == CNT_W'(CMD_W - 1)) begin
                bit_cnt_r  <= '0;
                rw_r       <= cmd_s[RW_BIT];
                addr_r     <= cmd_addr_s;
                cmd_seen_r <= 1'b1;
                tx_shift_r <= regs_r[cmd_addr_s];
                state_r    <= DATA;
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end else if (sclk_fall_s) begin
              miso_r <= 1'b0;
            end
          end
          DATA: begin
            if (sclk_rise_s) begin
              rx_shift_r <= {rx_shift_r[SH_W-2:0], mosi_sync_r};
              if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
                bit_cnt_r <= '0;
                if (rw_r) begin
                  regs_r[addr_r] <= word_s;
                  wr_strobe_r    <= 1'b1;
                  wr_addr_r      <= addr_r;
                end
                addr_r     <= next_addr_s;
                tx_shift_r <= regs_r[next_addr_s];
              end else begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end else if (sclk_fall_s) begin
              miso_r     <= rw_r ? 1'b0 : tx_shift_r[DATA_W-1];
              tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign MISO      = miso_r;
  assign regs      = regs_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign xact_done = xact_done_r;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed scoreboard bench for spi_reg_slave (DATA_W=8, ADDR_W=3, SCLK = clk/8).
module tb_spi_reg_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        CE0 = 1'b1;
  logic        MISO;
  logic [63:0] regs;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        xact_done;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] exp_regs [8];

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int xact_cnt = 0;
  int miso_bad = 0;
  logic wframe = 1'b0;

  spi_reg_slave #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .CE0       (CE0),
    .MISO      (MISO),
    .regs      (regs),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .xact_done (xact_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = exp_regs[i];
    return f;
  endfunction

  task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
    exp_regs[a] = d;
  endtask

  // Scoreboard side: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_strobe === 1'b1) begin
        strobe_cnt++;
        check("strobe_expected", 64'(wq.size() > 0), 64'd1);
        if (wq.size() > 0) begin
          wr_t e;
          e = wq.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", 64'(regs[wr_addr*8 +: 8]), 64'(e.data));
        end
      end
      if (xact_done === 1'b1) xact_cnt++;
      if (wframe && (MISO !== 1'b0)) miso_bad++;
    end
  end

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
  endtask

  task automatic spi_bit(input logic b, output logic r);
    MOSI = b;
    repeat (4) @(posedge clk);
    #1 r = MISO;
    SCLK = 1'b1;
    repeat (4) @(posedge clk);
    #1 SCLK = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] cmd, input int nbits, input logic [15:0] data,
                      input int rst_at, output logic [15:0] rx);
    logic r;
    rx = '0;
    wframe = cmd[7];
    @(posedge clk); #1 CE0 = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], r);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) pulse_rst();
      spi_bit(data[nbits-1-i], r);
      rx = {rx[14:0], r};
    end
    repeat (16) @(posedge clk);
    #1 CE0 = 1'b1;
    repeat (16) @(posedge clk);
    wframe = 1'b0;
  endtask

  initial begin
    logic [15:0] rx;
    int s0;
    int x0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("reset_regs", regs, 64'd0);
    check("reset_miso", 64'(MISO), 64'd0);
    check("reset_wr_strobe", 64'(wr_strobe), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_xact_done", 64'(xact_done), 64'd0);

    // 1: single write
    s0 = strobe_cnt; x0 = xact_cnt;
    push_wr(3'd2, 8'hA5);
    xfer(8'h82, 8, 16'h00A5, -1, rx);
    check("s1_regs", regs, exp_flat());
    check("s1_strobes", 64'(strobe_cnt - s0), 64'd1);
    check("s1_xact", 64'(xact_cnt - x0), 64'd1);
    check("s1_miso_zero", 64'(miso_bad), 64'd0);

    // 2: read back
    s0 = strobe_cnt;
    rq.push_back(exp_regs[2]);
    xfer(8'h02, 8, 16'h0000, -1, rx);
    check("s2_read", 64'(rx[7:0]), 64'(rq.pop_front()));
    check("s2_no_strobe", 64'(strobe_cnt - s0), 64'd0);

    // 3: two-word burst at the top address
    s0 = strobe_cnt;
    push_wr(3'd7, 8'h11);
`ifdef SPI_REG_AUTOINC_EN
    push_wr(3'd0, 8'h22);
`else
    push_wr(3'd7, 8'h22);
`endif
    xfer(8'h87, 16, 16'h1122, -1, rx);
    check("s3_regs", regs, exp_flat());
    check("s3_strobes", 64'(strobe_cnt - s0), 64'd2);
    rq.push_back(exp_regs[7]);
`ifdef SPI_REG_AUTOINC_EN
    rq.push_back(exp_regs[0]);
`else
    rq.push_back(exp_regs[7]);
`endif
    xfer(8'h07, 16, 16'h0000, -1, rx);
    check("s3_read_w0", 64'(rx[15:8]), 64'(rq.pop_front()));
    check("s3_read_w1", 64'(rx[7:0]), 64'(rq.pop_front()));

    // 4: abort after 5 data bits, then a clean write
    s0 = strobe_cnt; x0 = xact_cnt;
    xfer(8'h83, 5, 16'h0015, -1, rx);
    check("s4_abort_regs", regs, exp_flat());
    check("s4_abort_strobes", 64'(strobe_cnt - s0), 64'd0);
    check("s4_abort_xact", 64'(xact_cnt - x0), 64'd1);
    push_wr(3'd3, 8'h3C);
    xfer(8'h83, 8, 16'h003C, -1, rx);
    check("s4_rewrite_regs", regs, exp_flat());

    // 5: reset during bit 4 of a write data word
    s0 = strobe_cnt; x0 = xact_cnt;
    xfer(8'h84, 8, 16'h00F0, 4, rx);
    check("s5_regs_cleared", regs, 64'd0);
    check("s5_no_strobe", 64'(strobe_cnt - s0), 64'd0);
    check("s5_no_xact", 64'(xact_cnt - x0), 64'd0);
    push_wr(3'd5, 8'h5A);
    xfer(8'h85, 8, 16'h005A, -1, rx);
    check("s5_after_regs", regs, exp_flat());
    rq.push_back(exp_regs[5]);
    xfer(8'h05, 8, 16'h0000, -1, rx);
    check("s5_after_read", 64'(rx[7:0]), 64'(rq.pop_front()));

    // 6: command-only frame
    s0 = strobe_cnt; x0 = xact_cnt;
    xfer(8'h81, 0, 16'h0000, -1, rx);
    check("s6_regs", regs, exp_flat());
    check("s6_no_strobe", 64'(strobe_cnt - s0), 64'd0);
    check("s6_xact", 64'(xact_cnt - x0), 64'd1);

    check("miso_zero_in_writes", 64'(miso_bad), 64'd0);
    check("scoreboard_drained", 64'(wq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI slave (mode 0) that gives a Raspberry Pi master access to a bank of read/write registers on the icestick fabric. It replaces the fixed single-byte SPI exchange with command-addressed, multi-word transactions. All SPI pins are oversampled in the `clk` domain, with synchronisers and edge detection. The register bank is exposed flat to the fabric, for example to drive LEDs or feed datapath logic.

## Interface
- `DATA_W`, default 8: register and SPI data word width in bits, range 2..32.
- `ADDR_W`, default 3: address width, range 1..7. `NUM_REGS = 2**ADDR_W`.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `SCLK` in 1: SPI clock from the master; asynchronous.
- `MOSI` in 1: master-out data; asynchronous.
- `CE0` in 1: chip enable, active low; asynchronous.
- `MISO` out 1: slave-out data; registered.
- `regs` out `NUM_REGS*DATA_W`: flat register bank; reg *i* is at bits `[i*DATA_W +: DATA_W]`.
- `wr_strobe` out 1: one-cycle pulse when a register is written.
- `wr_addr` out `ADDR_W`: address of the register just written; valid with `wr_strobe`.
- `xact_done` out 1: one-cycle pulse when `CE0` deasserts after a command byte was completed.

## Operation
**Input conditioning**
- `SCLK`, `MOSI` and `CE0` each pass through a 2-flop synchroniser.
- Edge detect runs on the synchronised `SCLK` and `CE0`.
- `SCLK` frequency must be at most `clk`/8.

**Frame format**
- A frame starts on a `CE0` falling edge.
- Command byte, 8 bits, MSB first:
  - bit 7 = 1 means write, 0 means read.
  - bits 6:0 are the address; only bits `[ADDR_W-1:0]` are used and the upper bits are ignored.
- Data words of `DATA_W` bits follow, MSB first, any number per frame.

**Bit timing**
- `MOSI` is sampled on the synchronised `SCLK` rising edge.
- `MISO` is updated on the synchronised `SCLK` falling edge.

**States**
- `IDLE`:
  - `MISO` = 0 and the bit counter is cleared.
  - A `CE0` fall moves to `CMD`.
- `CMD`:
  - Shifts in 8 bits.
  - On the 8th rise: latch rw and addr, then move to `DATA`.
  - On a read: load the TX shifter with `reg[addr]`.
- `DATA`:
  - Shifts a `DATA_W`-bit word.
  - On the last rising edge of a write word: `reg[addr] <= {rx_shift, MOSI}`, and pulse `wr_strobe` with `wr_addr = addr`.
  - At the end of every word, in both directions: advance the address (see Configuration); on reads, reload the TX shifter with the new `reg[addr]`.
- From any state, a `CE0` rise returns to `IDLE`. Any partial word is discarded and no write occurs.

**MISO behaviour**
- During `CMD`, `MISO` = 0.
- The read MSB is driven on the falling edge after the 8th rise. It is valid before the first data rise.
- For a write frame, `MISO` = 0 throughout.

**Address arithmetic**
- The address is `ADDR_W` bits and wraps modulo `NUM_REGS`: `NUM_REGS-1` is followed by 0.

**Simultaneous events**
- `CE0` rising in the same cycle as the final `SCLK` rising edge of a word: the `CE0` rise wins and the word is discarded.
- The master guarantees that `CE0` is stable for at least 2 `SCLK` periods around a frame.

## Timing
**Reset values**
- `regs` = 0, `MISO` = 0, `wr_strobe` = 0, `wr_addr` = 0, `xact_done` = 0.
- State is `IDLE`.
- `CE0` synchroniser flops reset to 1 and `SCLK` synchroniser flops reset to 0, so no spurious edge appears after reset.

**Latency**
- Pin to edge-detect: 3 `clk` cycles.
- A write is visible on `regs` and `wr_strobe` 4 `clk` cycles after the pin-level `SCLK` rise of the last bit.
- `MISO` changes 4 `clk` cycles after the pin-level `SCLK` fall.

**Pulses**
- `xact_done` fires 4 cycles after the pin-level `CE0` rise, and only if a full command byte was received in the frame.

**Reset mid-frame**
- Everything returns to reset values at once.
- The frame in progress is ignored until `CE0` is seen high and then falls again.

## Configuration
- `SPI_REG_AUTOINC_EN` defined:
  - After each data word the address increments by 1, with wrap.
  - Multi-word frames access consecutive registers.
- `SPI_REG_AUTOINC_EN` undefined:
  - The address stays fixed for the whole frame.
  - Repeated writes overwrite the same register; repeated reads return the same register. On a read, each reload picks up any intervening write.

## Structure
- Package `spi_reg_pkg` holds:
  - the state typedef (`IDLE`, `CMD`, `DATA`);
  - the constant `CMD_W` = 8;
  - the constant `RW_BIT` = 7.
- Sub-module `spi_sync_edge`: a 2-flop synchroniser plus registered rise/fall pulses, with a reset-value parameter.
  - One instance each for `SCLK` and `CE0`.
  - `MOSI` uses only the synchroniser path.

## Test plan
All scenarios use `DATA_W`=8 and `ADDR_W`=3, with `SCLK` at `clk`/8.
1. **Single write.** Write cmd 0x82 then data 0xA5.
   - `regs[2]` = 0xA5.
   - One `wr_strobe` with `wr_addr` = 2.
   - `MISO` = 0 for the whole frame.
   - One `xact_done` pulse.
2. **Read back.** After scenario 1, read cmd 0x02 with 8 dummy clocks.
   - The master receives 0xA5.
   - No `wr_strobe`.
3. **Burst with wrap, AUTOINC_EN defined.** Write cmd 0x87 then 0x11, 0x22.
   - `regs[7]` = 0x11 and `regs[0]` = 0x22.
   - Undefined variant: `regs[7]` = 0x22, and `regs[0]` is unchanged.
4. **Abort.** Write cmd 0x83, then 5 data bits, then `CE0` rises.
   - `regs[3]` is unchanged and there is no `wr_strobe`.
   - One `xact_done` pulse.
   - The next frame with cmd 0x83 and data 0x3C writes 0x3C.
5. **Reset mid-frame.** Assert `rst` for 1 cycle during bit 4 of a write data word, with `CE0` still low.
   - All `regs` = 0.
   - The remaining bits cause no write.
   - A following new frame works normally.
6. **Command-only frame.** Write cmd 0x81, then `CE0` rises with no data.
   - No write.
   - `xact_done` pulses once.
